avr_mul_seq: RTL and testbench

Iterative 8×8 multiplier for the AVR core, covering MUL, MULS, MULSU, FMUL, FMULS and FMULSU. It sits directly downstream of the ALU operand selector. It consumes the low bytes of the selected operands A and B, which that stage routes for multiply opcodes without asserting any add, sub or logic enable. It returns a 16-bit product for R1:R0 together with the C and Z flags. Control stalls the pipeline while `mul_busy` is high.

---
 rtl/avr_mul_pkg.sv | 21 ++
 rtl/avr_mul_sign.sv | 17 +
 rtl/avr_mul_seq.sv | 179 +++++++++++++++++
 tb/tb_avr_mul_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/avr_mul_pkg.sv
// Shared constants and types for the AVR iterative 8x8 multiplier.
package avr_mul_pkg;

    // Number of shift-add iterations; fixed for 8-bit operands.
    localparam int unsigned ITER = 8;

    // mul_op[1:0] operand-signedness field; encoding 2'b11 behaves as MUL_UU.
    localparam logic [1:0] MUL_UU = 2'b00;
    localparam logic [1:0] MUL_SS = 2'b01;
    localparam logic [1:0] MUL_SU = 2'b10;

    // Bit position of the fractional (FMUL family) flag in mul_op.
    localparam int unsigned MUL_FRACT = 2;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } mul_state_e;

endpackage

// File: rtl/avr_mul_sign.sv
// Conditional two's-complement: passes data through, or negates it when neg_i is set.
module avr_mul_sign #(
    parameter int unsigned Width = 8
) (
    input  logic [Width-1:0] data_i,
    input  logic             neg_i,
    output logic [Width-1:0] data_o
);

    localparam logic [Width-1:0] One = {{(Width-1){1'b0}}, 1'b1};

    // Negation wraps modulo 2^Width, so the most negative value maps to itself.
    always_comb begin
        data_o = neg_i ? (~data_i + One) : data_i;
    end

endmodule

// File: rtl/avr_mul_seq.sv
// Iterative 8x8 multiplier for MUL/MULS/MULSU and FMUL/FMULS/FMULSU.
// Operands are reduced to magnitudes at start, multiplied unsigned by shift-add,
// and the sign is reapplied when the result is registered.
// Build option: define AVR_MUL_FRACT_EN to honour mul_op[2] (fractional left shift);
// without it the FMUL family behaves like its integer counterpart.
module avr_mul_seq #(
    parameter int unsigned ITER = avr_mul_pkg::ITER
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mul_start,
    input  logic [2:0]  mul_op,
    input  logic        mul_flush,
    input  logic [7:0]  alu_ai,
    input  logic [7:0]  alu_bi,
    output logic        mul_busy,
    output logic        mul_done,
    output logic [15:0] mul_result,
    output logic        mul_cf,
    output logic        mul_zf
);

    import avr_mul_pkg::*;

    localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;

    mul_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      mag_a_q, mag_a_d;
    logic [7:0]      mplr_q, mplr_d;
    logic [7:0]      acc_q, acc_d;
    logic            sign_q, sign_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [15:0]     result_q, result_d;
    logic            cf_q, cf_d;
    logic            zf_q, zf_d;

    logic            a_signed, b_signed;
    logic            a_neg, b_neg;
    logic [7:0]      mag_a, mag_b;
    logic [8:0]      sum;
    logic            last_iter;
    logic            start_go;
    logic [15:0]     prod_fin, p_fin, result_fin;

    // Decode operand signedness; 2'b11 falls through to unsigned x unsigned.
    always_comb begin
        a_signed = (mul_op[1:0] == MUL_SS) || (mul_op[1:0] == MUL_SU);
        b_signed = (mul_op[1:0] == MUL_SS);
    end

    assign a_neg = a_signed & alu_ai[7];
    assign b_neg = b_signed & alu_bi[7];

    avr_mul_sign #(.Width(8)) u_mag_a (
        .data_i (alu_ai),
        .neg_i  (a_neg),
        .data_o (mag_a)
    );

    avr_mul_sign #(.Width(8)) u_mag_b (
        .data_i (alu_bi),
        .neg_i  (b_neg),
        .data_o (mag_b)
    );

    // One shift-add step: the 9th sum bit is the carry shifted into the accumulator.
    assign sum       = {1'b0, acc_q} + {1'b0, (mplr_q[0] ? mag_a_q : 8'h00)};
    assign last_iter = (state_q == StCalc) && (cnt_q == CntW'(ITER - 1));
    assign prod_fin  = {sum[8:1], sum[0], mplr_q[7:1]};
    assign start_go  = !mul_flush && mul_start && (state_q != StCalc);

    avr_mul_sign #(.Width(16)) u_neg_p (
        .data_i (prod_fin),
        .neg_i  (sign_q),
        .data_o (p_fin)
    );

`ifdef AVR_MUL_FRACT_EN
    logic fract_q;

    // Remember whether the running operation is fractional.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fract_q <= 1'b0;
        end else if (start_go) begin
            fract_q <= mul_op[MUL_FRACT];
        end
    end

    assign result_fin = fract_q ? {p_fin[14:0], 1'b0} : p_fin;
`else
    logic unused_fract;
    assign unused_fract = mul_op[MUL_FRACT];
    assign result_fin   = p_fin;
`endif

    // Next-state logic; flush wins over everything and leaves the results untouched.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mag_a_d  = mag_a_q;
        mplr_d   = mplr_q;
        acc_d    = acc_q;
        sign_d   = sign_q;
        result_d = result_q;
        cf_d     = cf_q;
        zf_d     = zf_q;
        if (mul_flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (mul_start) begin
                        state_d = StCalc;
                        cnt_d   = '0;
                        mag_a_d = mag_a;
                        mplr_d  = mag_b;
                        acc_d   = 8'h00;
                        sign_d  = a_neg ^ b_neg;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StCalc: begin
                    cnt_d  = cnt_q + 1'b1;
                    acc_d  = sum[8:1];
                    mplr_d = {sum[0], mplr_q[7:1]};
                    if (last_iter) begin
                        state_d  = StDone;
                        result_d = result_fin;
                        cf_d     = p_fin[15];
                        zf_d     = (result_fin == 16'h0000);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        busy_d = (state_d == StCalc);
        done_d = (state_d == StDone);
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            mag_a_q  <= 8'h00;
            mplr_q   <= 8'h00;
            acc_q    <= 8'h00;
            sign_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 16'h0000;
            cf_q     <= 1'b0;
            zf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mag_a_q  <= mag_a_d;
            mplr_q   <= mplr_d;
            acc_q    <= acc_d;
            sign_q   <= sign_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            cf_q     <= cf_d;
            zf_q     <= zf_d;
        end
    end

    assign mul_busy   = busy_q;
    assign mul_done   = done_q;
    assign mul_result = result_q;
    assign mul_cf     = cf_q;
    assign mul_zf     = zf_q;

endmodule

// File: tb/tb_avr_mul_seq.sv
// Self-checking bench for avr_mul_seq: directed vector table, hand-written
// multi-cycle sequences, and randomized operations against an arithmetic model.
module tb_avr_mul_seq;

`ifdef AVR_MUL_FRACT_EN
    localparam bit FractEn = 1'b1;
`else
    localparam bit FractEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mul_start;
    logic [2:0]  mul_op;
    logic        mul_flush;
    logic [7:0]  alu_ai;
    logic [7:0]  alu_bi;
    logic        mul_busy;
    logic        mul_done;
    logic [15:0] mul_result;
    logic        mul_cf;
    logic        mul_zf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    avr_mul_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mul_start  (mul_start),
        .mul_op     (mul_op),
        .mul_flush  (mul_flush),
        .alu_ai     (alu_ai),
        .alu_bi     (alu_bi),
        .mul_busy   (mul_busy),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .mul_cf     (mul_cf),
        .mul_zf     (mul_zf)
    );

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        cf;
        logic        zf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: integer product of the operands as the op interprets them.
    function automatic logic [17:0] model(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        int          av;
        int          bv;
        int          p;
        logic [15:0] pl;
        logic [15:0] res;
        av  = (op[1:0] == 2'b01 || op[1:0] == 2'b10) ? int'($signed(a)) : int'(a);
        bv  = (op[1:0] == 2'b01) ? int'($signed(b)) : int'(b);
        p   = av * bv;
        pl  = p[15:0];
        res = (FractEn && op[2]) ? {pl[14:0], 1'b0} : pl;
        return {res, pl[15], (res == 16'h0000)};
    endfunction

    // Called 1 time unit after a rising edge; returns in cycle N+1.
    task automatic start_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        mul_start = 1'b1;
        mul_op    = op;
        alu_ai    = a;
        alu_bi    = b;
        @(posedge clk); #1;
        mul_start = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // From cycle N+1: busy for 8 cycles, then done in N+9 (returns in N+9).
    task automatic expect_run(input string tag);
        for (int i = 0; i < 8; i++) begin
            check({tag, "_busy"}, {30'd0, mul_busy, mul_done}, 32'b10);
            step();
        end
        check({tag, "_done"}, {30'd0, mul_busy, mul_done}, 32'b01);
    endtask

    vec_t vecs[9];

    initial begin
        logic [17:0] m;
        logic [15:0] prev;
        bit          saw_done;
        logic [2:0]  rop;
        logic [7:0]  ra;
        logic [7:0]  rb;

        vecs[0] = '{3'b000, 8'hFF, 8'hFF, 16'hFE01, 1'b1, 1'b0};
        vecs[1] = '{3'b001, 8'h80, 8'h80, 16'h4000, 1'b0, 1'b0};
        vecs[2] = '{3'b010, 8'hFF, 8'hFF, 16'hFF01, 1'b1, 1'b0};
        vecs[3] = '{3'b101, 8'h80, 8'h80, FractEn ? 16'h8000 : 16'h4000, 1'b0, 1'b0};
        vecs[4] = '{3'b100, 8'hC0, 8'h80, FractEn ? 16'hC000 : 16'h6000, 1'b0, 1'b0};
        vecs[5] = '{3'b000, 8'h00, 8'h37, 16'h0000, 1'b0, 1'b1};
        vecs[6] = '{3'b011, 8'h10, 8'h10, 16'h0100, 1'b0, 1'b0};
        vecs[7] = '{3'b110, 8'h40, 8'h80, FractEn ? 16'h4000 : 16'h2000, 1'b0, 1'b0};
        vecs[8] = '{3'b001, 8'h7F, 8'h81, 16'hC0FF, 1'b1, 1'b0};

        rst_n     = 1'b0;
        mul_start = 1'b0;
        mul_op    = 3'b000;
        mul_flush = 1'b0;
        alu_ai    = 8'h00;
        alu_bi    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {13'd0, mul_busy, mul_done, mul_result, mul_cf, mul_zf}, 32'd0);
        rst_n = 1'b1;
        step();

        // Directed vectors.
        foreach (vecs[i]) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            expect_run($sformatf("vec%0d", i));
            check($sformatf("vec%0d_result", i), {16'd0, mul_result}, {16'd0, vecs[i].res});
            check($sformatf("vec%0d_flags", i), {30'd0, mul_cf, mul_zf},
                  {30'd0, vecs[i].cf, vecs[i].zf});
            step();
            check($sformatf("vec%0d_pulse", i), {30'd0, mul_busy, mul_done}, 32'b00);
        end

        // Start pulsed in cycle N+3 is ignored.
        start_op(3'b000, 8'h12, 8'h34);
        step();
        step();
        mul_start = 1'b1;
        mul_op    = 3'b001;
        alu_ai    = 8'hFF;
        alu_bi    = 8'hFF;
        step();
        mul_start = 1'b0;
        repeat (5) step();
        check("ign_done", {31'd0, mul_done}, 32'd1);
        check("ign_result", {16'd0, mul_result}, 32'h03A8);
        step();
        check("ign_idle", {30'd0, mul_busy, mul_done}, 32'b00);

        // Back-to-back: new start in the DONE cycle.
        start_op(3'b000, 8'h05, 8'h07);
        expect_run("b2b1");
        check("b2b1_result", {16'd0, mul_result}, 32'h0023);
        start_op(3'b000, 8'h0A, 8'h0B);
        expect_run("b2b2");
        check("b2b2_result", {16'd0, mul_result}, 32'h006E);
        step();

        // Flush in cycle N+4: no done, result retained.
        prev = mul_result;
        start_op(3'b000, 8'hFF, 8'hFF);
        repeat (3) step();
        mul_flush = 1'b1;
        step();
        mul_flush = 1'b0;
        check("flush_busy_drop", {30'd0, mul_busy, mul_done}, 32'b00);
        saw_done = 1'b0;
        repeat (8) begin
            step();
            if (mul_done || mul_busy) saw_done = 1'b1;
        end
        check("flush_no_done", {31'd0, saw_done}, 32'd0);
        check("flush_result_kept", {16'd0, mul_result}, {16'd0, prev});

        // Flush on the final CALC cycle must not finalise.
        start_op(3'b001, 8'h80, 8'h7F);
        repeat (7) step();
        mul_flush = 1'b1;
        mul_start = 1'b1;
        step();
        mul_flush = 1'b0;
        mul_start = 1'b0;
        check("flush_last_state", {30'd0, mul_busy, mul_done}, 32'b00);
        check("flush_last_result", {15'd0, mul_result, mul_cf}, {15'd0, prev, 1'b0});

        // Reset during CALC in cycle N+5.
        start_op(3'b000, 8'hFF, 8'hFF);
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {13'd0, mul_busy, mul_done, mul_result, mul_cf, mul_zf},
              32'd0);
        step();
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (10) begin
            step();
            if (mul_done || mul_busy) saw_done = 1'b1;
        end
        check("rst_no_done", {31'd0, saw_done}, 32'd0);
        check("rst_result_zero", {16'd0, mul_result}, 32'd0);

        // Randomized operations against the arithmetic model.
        for (int k = 0; k < 40; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            m   = model(rop, ra, rb);
            start_op(rop, ra, rb);
            expect_run($sformatf("rnd%0d", k));
            check($sformatf("rnd%0d_op%0d_%02h_%02h", k, rop, ra, rb),
                  {13'd0, mul_result, mul_cf, mul_zf}, {14'd0, m});
            if (k % 2 == 1) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
